tx_pkt_buffer: RTL and testbench

TX_PKT_BUFFER -- requirements
Module: tx_pkt_buffer

---
 rtl/tx_pkt_buffer.sv | 73 +++++++
 tb/tb_tx_pkt_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_buffer.sv
// tx_pkt_buffer: store-and-forward 64-bit frame buffer with commit/rewind write side feeding the MAC TX packet interface
module tx_pkt_buffer #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk_156m25,
  input  logic                  reset_156m25,
  input  logic [63:0]           in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic [2:0]            in_mod,
  input  logic                  in_val,
  output logic [63:0]           pkt_tx_data,
  output logic                  pkt_tx_sop,
  output logic                  pkt_tx_eop,
  output logic                  pkt_tx_val,
  output logic [2:0]            pkt_tx_mod,
  input  logic                  pkt_tx_full,
  output logic [DEPTH_LOG2:0]   frame_cnt,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [DROP_CNT_W-1:0] drop_cnt
);
  localparam int PW = DEPTH_LOG2 + 1;
  localparam int DW = DROP_CNT_W + 1;
  localparam logic [DEPTH_LOG2:0] TOP = {1'b1, {DEPTH_LOG2{1'b0}}};
  typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;
  state_t state, state_n;
  logic [68:0] mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wr_ptr, wr_commit, commit_rd, rd_ptr, base;
  logic sop_go, restart, accept, full_b, ovf, we, commit, rd_go;
  logic [DROP_CNT_W:0] drop_sum;
  always_comb begin
    sop_go = in_val && in_sop;
    restart = sop_go && state == FRAME;
    base = sop_go ? wr_commit : wr_ptr;
    full_b = (base ^ rd_ptr) == TOP;
    accept = in_val && (sop_go || state == FRAME);
    ovf = accept && full_b;
    we = accept && !full_b;
    commit = we && in_eop;
    state_n = ovf ? (in_eop ? IDLE : DISCARD) :
              we ? (in_eop ? IDLE : FRAME) :
              (state == DISCARD && in_val && in_eop) ? IDLE : state;
    drop_sum = {1'b0, drop_cnt} + DW'(restart) + DW'(ovf);
    rd_go = !pkt_tx_full && rd_ptr != commit_rd;
  end
  always_ff @(posedge clk_156m25)
    if (we) mem[base[DEPTH_LOG2-1:0]] <= {in_data, in_sop, in_eop, in_eop ? in_mod : 3'd0};
  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      state <= IDLE;
      wr_ptr <= '0;
      wr_commit <= '0;
      commit_rd <= '0;
      rd_ptr <= '0;
      frame_cnt <= '0;
      drop_cnt <= '0;
      pkt_tx_val <= 1'b0;
      {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} <= '0;
    end else begin
      state <= state_n;
      wr_ptr <= ovf ? wr_commit : we ? base + PW'(1) : wr_ptr;
      wr_commit <= commit ? base + PW'(1) : wr_commit;
      commit_rd <= wr_commit;
      rd_ptr <= rd_ptr + PW'(rd_go);
      frame_cnt <= frame_cnt + PW'(commit) - PW'(pkt_tx_val && pkt_tx_eop);
      drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      pkt_tx_val <= rd_go;
      if (rd_go) {pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod} <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end
  end
  assign fifo_level = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_tx_pkt_buffer.sv
// tb_tx_pkt_buffer: directed table and sequence checks of tx_pkt_buffer at DEPTH_LOG2=4, DROP_CNT_W=2
module tb_tx_pkt_buffer;
  localparam logic [63:0] DA = 64'hAAAA_0000_0000_0000;
  localparam logic [63:0] DB = 64'hBBBB_0000_0000_0000;
  localparam logic [63:0] DC = 64'hCCCC_0000_0000_0000;
  localparam logic [63:0] DD = 64'hDDDD_0000_0000_0000;
  localparam logic [63:0] DE = 64'hEEEE_0000_0000_0000;
  localparam logic [63:0] DF = 64'hFFFF_0000_0000_0000;
  localparam logic [63:0] DG = 64'h1234_0000_0000_0000;
  localparam logic [63:0] DH = 64'h5678_0000_0000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] in_data = '0;
  logic in_sop = 1'b0, in_eop = 1'b0, in_val = 1'b0, pkt_tx_full = 1'b0;
  logic [2:0] in_mod = '0;
  logic [63:0] pkt_tx_data;
  logic pkt_tx_sop, pkt_tx_eop, pkt_tx_val;
  logic [2:0] pkt_tx_mod;
  logic [4:0] frame_cnt, fifo_level;
  logic [1:0] drop_cnt;
  int n_vec = 0, n_err = 0, fc_peak = 0;
  logic full_q = 1'b0;
  typedef struct {logic [63:0] d; logic s, e; logic [2:0] m;} word_t;
  word_t q[$];
  typedef struct {
    logic v, s, e; logic [2:0] m; logic [63:0] d; logic f;
    logic ev, es, ee; logic [2:0] em; logic [63:0] ed; int fc, lvl;
  } vec_t;
  vec_t tbl[23];
  tx_pkt_buffer #(.DEPTH_LOG2(4), .DROP_CNT_W(2)) dut (
    .clk_156m25(clk), .reset_156m25(reset),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod), .in_val(in_val),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
    .pkt_tx_val(pkt_tx_val), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
    .frame_cnt(frame_cnt), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(posedge clk) full_q <= pkt_tx_full;
  always @(negedge clk) begin
    if (!reset) begin
      if (full_q) check("no_val_after_full", {63'd0, pkt_tx_val}, 64'd0);
      if (pkt_tx_val) begin
        q.push_back('{pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod});
        if (!pkt_tx_eop) check("mod_zero_non_eop", {61'd0, pkt_tx_mod}, 64'd0);
      end
      if (int'(frame_cnt) > fc_peak) fc_peak = int'(frame_cnt);
    end
  end
  function automatic vec_t mk(input logic v, s, e, input logic [2:0] m, input logic [63:0] d, input logic f,
                              input logic ev, es, ee, input logic [2:0] em, input logic [63:0] ed,
                              input int fc, lvl);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.m = m; r.d = d; r.f = f;
    r.ev = ev; r.es = es; r.ee = ee; r.em = em; r.ed = ed; r.fc = fc; r.lvl = lvl;
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, s, e, input logic [2:0] m, input logic [63:0] d);
    in_val = v; in_sop = s; in_eop = e; in_mod = m; in_data = d;
  endtask
  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0);
    repeat (n) step();
  endtask
  task automatic do_reset();
    reset = 1'b1;
    pkt_tx_full = 1'b0;
    idle(2);
    reset = 1'b0;
    q.delete();
    fc_peak = 0;
  endtask
  task automatic send_frame(input int n, input logic [63:0] base, input logic [2:0] m);
    for (int i = 0; i < n; i++) begin
      drive(1, i == 0, i == n - 1, i == n - 1 ? m : 3'd0, base + 64'(i));
      step();
    end
    drive(0, 0, 0, 0, 0);
  endtask
  task automatic check_frame(input string name, input int n, input logic [63:0] base, input logic [2:0] m);
    check({name, "_words"}, 64'(q.size()), 64'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), q[i].d, base + 64'(i));
      check($sformatf("%s_sop%0d", name, i), {63'd0, q[i].s}, {63'd0, i == 0});
      check($sformatf("%s_eop%0d", name, i), {63'd0, q[i].e}, {63'd0, i == n - 1});
      check($sformatf("%s_mod%0d", name, i), {61'd0, q[i].m}, {61'd0, i == n - 1 ? m : 3'd0});
    end
  endtask
  initial begin
    tbl[0]  = mk(1, 1, 0, 7, DA,     0, 0, 0, 0, 0, 0,      0, 1);
    tbl[1]  = mk(1, 0, 0, 7, DA + 1, 0, 0, 0, 0, 0, 0,      0, 2);
    tbl[2]  = mk(1, 0, 0, 7, DA + 2, 0, 0, 0, 0, 0, 0,      0, 3);
    tbl[3]  = mk(1, 0, 1, 5, DA + 3, 0, 0, 0, 0, 0, 0,      1, 4);
    tbl[4]  = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,      1, 4);
    tbl[5]  = mk(0, 0, 0, 0, 0,      0, 1, 1, 0, 0, DA,     1, 3);
    tbl[6]  = mk(0, 0, 0, 0, 0,      0, 1, 0, 0, 0, DA + 1, 1, 2);
    tbl[7]  = mk(0, 0, 0, 0, 0,      0, 1, 0, 0, 0, DA + 2, 1, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0,      0, 1, 0, 1, 5, DA + 3, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,      0, 0);
    tbl[10] = mk(1, 1, 0, 7, DB,     0, 0, 0, 0, 0, 0,      0, 1);
    tbl[11] = mk(1, 0, 0, 7, DB + 1, 0, 0, 0, 0, 0, 0,      0, 2);
    tbl[12] = mk(1, 0, 0, 7, DB + 2, 0, 0, 0, 0, 0, 0,      0, 3);
    tbl[13] = mk(1, 0, 1, 5, DB + 3, 0, 0, 0, 0, 0, 0,      1, 4);
    tbl[14] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,      1, 4);
    tbl[15] = mk(0, 0, 0, 0, 0,      0, 1, 1, 0, 0, DB,     1, 3);
    tbl[16] = mk(0, 0, 0, 0, 0,      0, 1, 0, 0, 0, DB + 1, 1, 2);
    tbl[17] = mk(0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,      1, 2);
    tbl[18] = mk(0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,      1, 2);
    tbl[19] = mk(0, 0, 0, 0, 0,      1, 0, 0, 0, 0, 0,      1, 2);
    tbl[20] = mk(0, 0, 0, 0, 0,      0, 1, 0, 0, 0, DB + 2, 1, 1);
    tbl[21] = mk(0, 0, 0, 0, 0,      0, 1, 0, 1, 5, DB + 3, 1, 0);
    tbl[22] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0,      0, 0);
    idle(2);
    check("rst_val", {63'd0, pkt_tx_val}, 64'd0);
    check("rst_sop_eop", {62'd0, pkt_tx_sop, pkt_tx_eop}, 64'd0);
    check("rst_mod", {61'd0, pkt_tx_mod}, 64'd0);
    check("rst_data", pkt_tx_data, 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].d);
      pkt_tx_full = tbl[i].f;
      step();
      check($sformatf("t%0d_val", i), {63'd0, pkt_tx_val}, {63'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        check($sformatf("t%0d_sop", i), {63'd0, pkt_tx_sop}, {63'd0, tbl[i].es});
        check($sformatf("t%0d_eop", i), {63'd0, pkt_tx_eop}, {63'd0, tbl[i].ee});
        check($sformatf("t%0d_mod", i), {61'd0, pkt_tx_mod}, {61'd0, tbl[i].em});
        check($sformatf("t%0d_data", i), pkt_tx_data, tbl[i].ed);
      end
      check($sformatf("t%0d_frame_cnt", i), 64'(frame_cnt), 64'(tbl[i].fc));
      check($sformatf("t%0d_fifo_level", i), 64'(fifo_level), 64'(tbl[i].lvl));
    end
    pkt_tx_full = 1'b0;
    check("tbl_drop_cnt", 64'(drop_cnt), 64'd0);
    do_reset();
    drive(1, 0, 1, 2, DC);
    step();
    idle(6);
    check("stray_drop_cnt", 64'(drop_cnt), 64'd0);
    check("stray_words", 64'(q.size()), 64'd0);
    drive(1, 1, 0, 0, DC); step();
    drive(1, 0, 0, 0, DC + 1); step();
    drive(1, 1, 0, 0, DD); step();
    drive(1, 0, 1, 3, DD + 1); step();
    idle(8);
    check("resop_drop_cnt", 64'(drop_cnt), 64'd1);
    check_frame("resop", 2, DD, 3);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, i == 19, 0, DC + 64'(i));
      step();
      if (i == 15) check("long_level_full", 64'(fifo_level), 64'd16);
      if (i == 16) check("long_level_rewound", 64'(fifo_level), 64'd0);
    end
    send_frame(3, DD, 3);
    idle(10);
    check("long_drop_cnt", 64'(drop_cnt), 64'd1);
    check_frame("long", 3, DD, 3);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 0, DE + 64'(i));
      step();
    end
    idle(10);
    check("single_words", 64'(q.size()), 64'd8);
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      check($sformatf("single_data%0d", i), q[i].d, DE + 64'(i));
      check($sformatf("single_sop_eop%0d", i), {62'd0, q[i].s, q[i].e}, 64'd3);
      check($sformatf("single_mod%0d", i), {61'd0, q[i].m}, 64'd0);
    end
    check("single_peak_le8", {63'd0, fc_peak <= 8}, 64'd1);
    check("single_peak_nonzero", {63'd0, fc_peak > 0}, 64'd1);
    check("single_frame_cnt_end", 64'(frame_cnt), 64'd0);
    do_reset();
    send_frame(6, DF, 1);
    for (int k = 0; k < 10 && !pkt_tx_val; k++) step();
    check("rst_mid_first_word", {63'd0, pkt_tx_val}, 64'd1);
    step();
    reset = 1'b1;
    step();
    check("rst_mid_val", {63'd0, pkt_tx_val}, 64'd0);
    check("rst_mid_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_mid_frame_cnt", 64'(frame_cnt), 64'd0);
    reset = 1'b0;
    q.delete();
    send_frame(2, DG, 6);
    idle(8);
    check_frame("rst_mid", 2, DG, 6);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, DH + 64'(i));
      step();
    end
    drive(1, 0, 1, 2, DH + 5);
    step();
    idle(8);
    check("sat_drop_cnt", 64'(drop_cnt), 64'd3);
    check_frame("sat", 2, DH + 4, 2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
